// File: rtl/sc_lane_shifter_pkg.sv
// Shared game-wide encodings for the lane shifter: FSM states, direction codes
// and the counter sizing helper.
package sc_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CRASH = 2'b10
   } laneState_t;

   localparam logic [1:0] DIR_HOLD  = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;

   // Bits needed to hold (max(a, b) - 1), never less than one bit.
   function automatic int cntWidth(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sc_lane_shifter_if.sv
// Control inputs and lane/status outputs of the player lane shifter.
// The game logic side is the master; the shifter is the slave.
interface sc_lane_shifter_if #(
   parameter int WIDTH = 8
);

   logic             sc_lane_shifter_load_InLow;
   logic [1:0]       sc_lane_shifter_shiftselection_In;
   logic             sc_lane_shifter_tick_In;
   logic             sc_lane_shifter_crash_In;
   logic [WIDTH-1:0] sc_lane_shifter_data_OutBUS;
   logic             sc_lane_shifter_visible_Out;
   logic [1:0]       sc_lane_shifter_state_Out;
   logic             sc_lane_shifter_atbound_Out;

   modport master (
      output sc_lane_shifter_load_InLow,
      output sc_lane_shifter_shiftselection_In,
      output sc_lane_shifter_tick_In,
      output sc_lane_shifter_crash_In,
      input  sc_lane_shifter_data_OutBUS,
      input  sc_lane_shifter_visible_Out,
      input  sc_lane_shifter_state_Out,
      input  sc_lane_shifter_atbound_Out
   );

   modport slave (
      input  sc_lane_shifter_load_InLow,
      input  sc_lane_shifter_shiftselection_In,
      input  sc_lane_shifter_tick_In,
      input  sc_lane_shifter_crash_In,
      output sc_lane_shifter_data_OutBUS,
      output sc_lane_shifter_visible_Out,
      output sc_lane_shifter_state_Out,
      output sc_lane_shifter_atbound_Out
   );

endinterface

// File: rtl/sc_lane_shifter_downcounter.sv
// Loadable down-counter that decrements only when enabled by the frame tick
// and saturates at zero; clear beats load, which beats decrement.
module sc_tick_downcounter #(
   parameter int CNT_W = 3
) (
   input  logic             SC_RegSHIFTER_P1_CLOCK_50,
   input  logic             SC_RegSHIFTER_P1_RESET_InHigh,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] loadValue,
   input  logic             dec,
   output logic             isZero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge SC_RegSHIFTER_P1_CLOCK_50 or posedge SC_RegSHIFTER_P1_RESET_InHigh) begin
      if (SC_RegSHIFTER_P1_RESET_InHigh) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign isZero = (count == '0);

endmodule

// File: rtl/sc_lane_shifter.sv
// One-hot player lane register with bounded, tick-paced moves, hold-to-repeat,
// and a crash/respawn sequence that blinks the car.
module sc_lane_shifter
   import sc_game_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int LANE_MIN     = 4,
   parameter int LANE_MAX     = 7,
   parameter int START_LANE   = 5,
   parameter int REPEAT_TICKS = 4,
   parameter int CRASH_TICKS  = 8
) (
   input logic               sc_lane_shifter_CLOCK_50,
   input logic               sc_lane_shifter_RESET_InHigh,
   sc_lane_shifter_if.slave  bus
);

   localparam int               CNT_W         = cntWidth(REPEAT_TICKS, CRASH_TICKS);
   localparam logic [CNT_W-1:0] REPEAT_RELOAD = CNT_W'(REPEAT_TICKS - 1);
   localparam logic [CNT_W-1:0] CRASH_RELOAD  = CNT_W'(CRASH_TICKS - 1);
   localparam logic [WIDTH-1:0] START_POS     = {{(WIDTH-1){1'b0}}, 1'b1} << START_LANE;

   logic             loadN;
   logic [1:0]       dirSel;
   logic             tick;
   logic             crash;

   laneState_t       state;
   logic [WIDTH-1:0] lanePos;
   logic             visible;
   logic [1:0]       lastDir;

   logic             isDir;
   logic             atLimit;
   logic [WIDTH-1:0] movedPos;
   logic             takeMove;
   logic             repClear;
   logic             repLoad;
   logic             repDec;
   logic             repZero;
   logic             crashClear;
   logic             crashLoad;
   logic             crashDec;
   logic             crashZero;

   assign loadN  = bus.sc_lane_shifter_load_InLow;
   assign dirSel = bus.sc_lane_shifter_shiftselection_In;
   assign tick   = bus.sc_lane_shifter_tick_In;
   assign crash  = bus.sc_lane_shifter_crash_In;

   // Counter control and move decision; priority is load > crash > tick work.
   always_comb begin
      isDir      = (dirSel == DIR_LEFT) || (dirSel == DIR_RIGHT);
      atLimit    = (dirSel == DIR_LEFT) ? lanePos[LANE_MAX] : lanePos[LANE_MIN];
      movedPos   = (dirSel == DIR_LEFT) ? (lanePos << 1) : (lanePos >> 1);
      takeMove   = 1'b0;
      repClear   = 1'b0;
      repLoad    = 1'b0;
      repDec     = 1'b0;
      crashClear = 1'b0;
      crashLoad  = 1'b0;
      crashDec   = 1'b0;
      if (!loadN) begin
         repClear   = 1'b1;
         crashClear = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (crash) begin
                  repClear  = 1'b1;
                  crashLoad = 1'b1;
               end else if (tick) begin
                  if (!isDir) begin
                     repClear = 1'b1;
                  end else if ((dirSel != lastDir) || repZero) begin
                     takeMove = 1'b1;
                     repLoad  = 1'b1;
                  end else begin
                     repDec = 1'b1;
                  end
               end
            end
            ST_CRASH: begin
               if (tick) begin
                  if (crashZero) begin
                     crashClear = 1'b1;
                     repClear   = 1'b1;
                  end else begin
                     crashDec = 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Main FSM; a clamped move still counts as a move for repeat pacing.
   always_ff @(posedge sc_lane_shifter_CLOCK_50 or posedge sc_lane_shifter_RESET_InHigh) begin
      if (sc_lane_shifter_RESET_InHigh) begin
         state   <= ST_IDLE;
         lanePos <= '0;
         visible <= 1'b0;
         lastDir <= DIR_HOLD;
      end else if (!loadN) begin
         state   <= ST_RUN;
         lanePos <= START_POS;
         visible <= 1'b1;
         lastDir <= DIR_HOLD;
      end else begin
         case (state)
            ST_RUN: begin
               if (crash) begin
                  state   <= ST_CRASH;
                  visible <= 1'b0;
               end else if (tick) begin
                  lastDir <= isDir ? dirSel : DIR_HOLD;
                  if (takeMove && !atLimit) begin
                     lanePos <= movedPos;
                  end
               end
            end
            ST_CRASH: begin
               if (tick) begin
                  if (crashZero) begin
                     state   <= ST_RUN;
                     lanePos <= START_POS;
                     visible <= 1'b1;
                     lastDir <= DIR_HOLD;
                  end else begin
                     visible <= ~visible;
                  end
               end
            end
            ST_IDLE: begin
            end
            default: begin
               state   <= ST_IDLE;
               lanePos <= '0;
               visible <= 1'b0;
            end
         endcase
      end
   end

   sc_tick_downcounter #(.CNT_W(CNT_W)) repeatCounter (
      .SC_RegSHIFTER_P1_CLOCK_50     (sc_lane_shifter_CLOCK_50),
      .SC_RegSHIFTER_P1_RESET_InHigh (sc_lane_shifter_RESET_InHigh),
      .clear                         (repClear),
      .load                          (repLoad),
      .loadValue                     (REPEAT_RELOAD),
      .dec                           (repDec),
      .isZero                        (repZero)
   );

   sc_tick_downcounter #(.CNT_W(CNT_W)) crashCounter (
      .SC_RegSHIFTER_P1_CLOCK_50     (sc_lane_shifter_CLOCK_50),
      .SC_RegSHIFTER_P1_RESET_InHigh (sc_lane_shifter_RESET_InHigh),
      .clear                         (crashClear),
      .load                          (crashLoad),
      .loadValue                     (CRASH_RELOAD),
      .dec                           (crashDec),
      .isZero                        (crashZero)
   );

   assign bus.sc_lane_shifter_data_OutBUS = lanePos;
   assign bus.sc_lane_shifter_visible_Out = visible;
   assign bus.sc_lane_shifter_state_Out   = state;
   assign bus.sc_lane_shifter_atbound_Out = lanePos[LANE_MIN] | lanePos[LANE_MAX];

endmodule

// File: tb/tb_sc_lane_shifter.sv
// Directed bench for sc_lane_shifter with default parameters; every expected
// value below is worked out by hand from the lane/repeat/crash rules.
module tb_sc_lane_shifter;

   logic clock50;
   logic resetHigh;
   int   checksTotal;
   int   checksPassed;

   sc_lane_shifter_if #(.WIDTH(8)) laneBus ();

   sc_lane_shifter #(
      .WIDTH        (8),
      .LANE_MIN     (4),
      .LANE_MAX     (7),
      .START_LANE   (5),
      .REPEAT_TICKS (4),
      .CRASH_TICKS  (8)
   ) dut (
      .sc_lane_shifter_CLOCK_50     (clock50),
      .sc_lane_shifter_RESET_InHigh (resetHigh),
      .bus                          (laneBus)
   );

   initial clock50 = 1'b0;
   always #5 clock50 = ~clock50;

   // Drive one cycle of inputs, let the DUT sample them, then drop the strobes.
   task automatic applyStimulus(input logic loadN, input logic [1:0] dir,
                                input logic tk, input logic cr);
      laneBus.sc_lane_shifter_load_InLow        = loadN;
      laneBus.sc_lane_shifter_shiftselection_In = dir;
      laneBus.sc_lane_shifter_tick_In           = tk;
      laneBus.sc_lane_shifter_crash_In          = cr;
      @(posedge clock50);
      #1;
      laneBus.sc_lane_shifter_load_InLow = 1'b1;
      laneBus.sc_lane_shifter_tick_In    = 1'b0;
      laneBus.sc_lane_shifter_crash_In   = 1'b0;
   endtask

   task automatic test_reset();
      resetHigh = 1'b1;
      laneBus.sc_lane_shifter_load_InLow        = 1'b1;
      laneBus.sc_lane_shifter_shiftselection_In = 2'b00;
      laneBus.sc_lane_shifter_tick_In           = 1'b0;
      laneBus.sc_lane_shifter_crash_In          = 1'b0;
      #12;
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h00) $display("[TB] FAIL reset_data got %h want 00", laneBus.sc_lane_shifter_data_OutBUS);
      else checksPassed++;
      checksTotal++;
      if (laneBus.sc_lane_shifter_state_Out !== 2'b00) $display("[TB] FAIL reset_state got %b want 00", laneBus.sc_lane_shifter_state_Out);
      else checksPassed++;
      checksTotal++;
      if (laneBus.sc_lane_shifter_visible_Out !== 1'b0 || laneBus.sc_lane_shifter_atbound_Out !== 1'b0)
         $display("[TB] FAIL reset_flags got vis=%b atb=%b want 0 0", laneBus.sc_lane_shifter_visible_Out, laneBus.sc_lane_shifter_atbound_Out);
      else checksPassed++;
      resetHigh = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'b01, 1'b1, 1'b1);
         checksTotal++;
         if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h00 || laneBus.sc_lane_shifter_state_Out !== 2'b00)
            $display("[TB] FAIL idle_ignore got data=%h state=%b want 00 00", laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_state_Out);
         else checksPassed++;
      end
   endtask

   task automatic test_load();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h20) $display("[TB] FAIL load_data got %h want 20", laneBus.sc_lane_shifter_data_OutBUS);
      else checksPassed++;
      checksTotal++;
      if (laneBus.sc_lane_shifter_state_Out !== 2'b01) $display("[TB] FAIL load_state got %b want 01", laneBus.sc_lane_shifter_state_Out);
      else checksPassed++;
      checksTotal++;
      if (laneBus.sc_lane_shifter_visible_Out !== 1'b1 || laneBus.sc_lane_shifter_atbound_Out !== 1'b0)
         $display("[TB] FAIL load_flags got vis=%b atb=%b want 1 0", laneBus.sc_lane_shifter_visible_Out, laneBus.sc_lane_shifter_atbound_Out);
      else checksPassed++;
   endtask

   task automatic test_hold_repeat();
      logic [7:0] expData [10];
      logic       expBound [10];
      expData  = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      expBound = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
         checksTotal++;
         if (laneBus.sc_lane_shifter_data_OutBUS !== expData[i] || laneBus.sc_lane_shifter_atbound_Out !== expBound[i])
            $display("[TB] FAIL hold_tick%0d got data=%h atb=%b want %h %b", i + 1,
                     laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_atbound_Out, expData[i], expBound[i]);
         else checksPassed++;
         applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
         checksTotal++;
         if (laneBus.sc_lane_shifter_data_OutBUS !== expData[i])
            $display("[TB] FAIL hold_notick%0d got %h want %h", i + 1, laneBus.sc_lane_shifter_data_OutBUS, expData[i]);
         else checksPassed++;
      end
   endtask

   task automatic test_right_clamp();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h10 || laneBus.sc_lane_shifter_atbound_Out !== 1'b1)
         $display("[TB] FAIL right_move got data=%h atb=%b want 10 1", laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_atbound_Out);
      else checksPassed++;
      applyStimulus(1'b1, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h10 || laneBus.sc_lane_shifter_atbound_Out !== 1'b1)
         $display("[TB] FAIL right_clamp got data=%h atb=%b want 10 1", laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_atbound_Out);
      else checksPassed++;
      // Left without a tick must not move; the next left tick is a new direction.
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h20 || laneBus.sc_lane_shifter_atbound_Out !== 1'b0)
         $display("[TB] FAIL reverse_move got data=%h atb=%b want 20 0", laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_atbound_Out);
      else checksPassed++;
   endtask

   task automatic test_crash();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
      checksTotal++;
      if (laneBus.sc_lane_shifter_state_Out !== 2'b10 || laneBus.sc_lane_shifter_data_OutBUS !== 8'h40 || laneBus.sc_lane_shifter_visible_Out !== 1'b0)
         $display("[TB] FAIL crash_enter got state=%b data=%h vis=%b want 10 40 0", laneBus.sc_lane_shifter_state_Out,
                  laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_visible_Out);
      else checksPassed++;
      for (int k = 1; k <= 8; k++) begin
         logic [1:0] expState;
         logic [7:0] expData;
         logic       expVis;
         applyStimulus(1'b1, 2'b10, 1'b1, (k == 3));
         expState = (k == 8) ? 2'b01 : 2'b10;
         expData  = (k == 8) ? 8'h20 : 8'h40;
         expVis   = (k == 8) ? 1'b1 : k[0];
         checksTotal++;
         if (laneBus.sc_lane_shifter_state_Out !== expState || laneBus.sc_lane_shifter_data_OutBUS !== expData ||
             laneBus.sc_lane_shifter_visible_Out !== expVis)
            $display("[TB] FAIL crash_tick%0d got state=%b data=%h vis=%b want %b %h %b", k, laneBus.sc_lane_shifter_state_Out,
                     laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_visible_Out, expState, expData, expVis);
         else checksPassed++;
         if (k < 8) begin
            applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
            checksTotal++;
            if (laneBus.sc_lane_shifter_visible_Out !== expVis)
               $display("[TB] FAIL crash_notick%0d got vis=%b want %b", k, laneBus.sc_lane_shifter_visible_Out, expVis);
            else checksPassed++;
         end
      end
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h40)
         $display("[TB] FAIL respawn_move got %h want 40", laneBus.sc_lane_shifter_data_OutBUS);
      else checksPassed++;
   endtask

   task automatic test_load_priority();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b1);
      checksTotal++;
      if (laneBus.sc_lane_shifter_state_Out !== 2'b01 || laneBus.sc_lane_shifter_data_OutBUS !== 8'h20 || laneBus.sc_lane_shifter_visible_Out !== 1'b1)
         $display("[TB] FAIL load_in_crash got state=%b data=%h vis=%b want 01 20 1", laneBus.sc_lane_shifter_state_Out,
                  laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_visible_Out);
      else checksPassed++;
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      checksTotal++;
      if (laneBus.sc_lane_shifter_state_Out !== 2'b01 || laneBus.sc_lane_shifter_data_OutBUS !== 8'h20 || laneBus.sc_lane_shifter_visible_Out !== 1'b1)
         $display("[TB] FAIL load_vs_crash got state=%b data=%h vis=%b want 01 20 1", laneBus.sc_lane_shifter_state_Out,
                  laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_visible_Out);
      else checksPassed++;
   endtask

   task automatic test_reset_midcrash();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'b00, 1'b1, 1'b0);
      #3;
      resetHigh = 1'b1;
      #1;
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h00 || laneBus.sc_lane_shifter_state_Out !== 2'b00 ||
          laneBus.sc_lane_shifter_visible_Out !== 1'b0 || laneBus.sc_lane_shifter_atbound_Out !== 1'b0)
         $display("[TB] FAIL async_reset got data=%h state=%b vis=%b atb=%b want 00 00 0 0", laneBus.sc_lane_shifter_data_OutBUS,
                  laneBus.sc_lane_shifter_state_Out, laneBus.sc_lane_shifter_visible_Out, laneBus.sc_lane_shifter_atbound_Out);
      else checksPassed++;
      #2;
      resetHigh = 1'b0;
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h00 || laneBus.sc_lane_shifter_state_Out !== 2'b00)
         $display("[TB] FAIL post_reset_idle got data=%h state=%b want 00 00", laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_state_Out);
      else checksPassed++;
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checksTotal++;
      if (laneBus.sc_lane_shifter_data_OutBUS !== 8'h20 || laneBus.sc_lane_shifter_state_Out !== 2'b01)
         $display("[TB] FAIL post_reset_load got data=%h state=%b want 20 01", laneBus.sc_lane_shifter_data_OutBUS, laneBus.sc_lane_shifter_state_Out);
      else checksPassed++;
   endtask

   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      test_reset();
      test_load();
      test_hold_repeat();
      test_right_clamp();
      test_crash();
      test_load_priority();
      test_reset_midcrash();
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
